cmd_sched: RTL and testbench

CMD_SCHED -- requirements
Module: cmd_sched

---
 rtl/cmd_sched.sv | 161 ++++++++++++++++
 tb/tb_cmd_sched.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_sched.sv
// Command scheduler: queues engine commands, issues DMA read bursts for the
// active command, tracks per-engine completion and raises a sticky interrupt.
module cmd_sched #(
    parameter int unsigned NUM_ENG   = 4,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned LEN_W     = 16,
    parameter int unsigned MAX_BURST = 16,
    parameter int unsigned CQ_DEPTH  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [NUM_ENG-1:0] cmd_mask,
    input  logic [ADDR_W-1:0]  cmd_raddr,
    input  logic [ADDR_W-1:0]  cmd_waddr,
    input  logic [LEN_W-1:0]   cmd_words,
    output logic [NUM_ENG-1:0] eng_ready,
    input  logic [NUM_ENG-1:0] eng_valid,
    output logic               rd_req,
    input  logic               rd_ack,
    output logic [ADDR_W-1:0]  rd_addr,
    output logic [7:0]         rd_len,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic               busy,
    output logic               irq,
    input  logic               irq_clr,
    output logic [15:0]        cmd_cnt
);

    localparam int unsigned PTR_W = $clog2(CQ_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {StIdle, StLoad, StBurst, StWait, StDone} state_e;

    state_e state_q, state_d;

    // Command queue storage and pointers
    logic [NUM_ENG-1:0] mask_mem  [CQ_DEPTH];
    logic [ADDR_W-1:0]  raddr_mem [CQ_DEPTH];
    logic [ADDR_W-1:0]  waddr_mem [CQ_DEPTH];
    logic [LEN_W-1:0]   words_mem [CQ_DEPTH];
    logic [PTR_W-1:0]   wptr_q, rptr_q;
    logic [CNT_W-1:0]   occ_q;
    logic               push, pop;

    // Active command state
    logic [NUM_ENG-1:0] mask_q, done_q, eng_ready_q, eng_hit;
    logic [ADDR_W-1:0]  addr_q, wr_addr_q;
    logic [LEN_W-1:0]   rem_q;
    logic [7:0]         burst_len;
    logic               irq_q;
    logic [15:0]        cmd_cnt_q;

    assign cmd_ready = (occ_q < CNT_W'(CQ_DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state_q == StLoad);

    // A completion only counts for an engine that is still being held.
    assign eng_hit   = eng_valid & eng_ready_q;

    assign burst_len = (rem_q > LEN_W'(MAX_BURST)) ? 8'(MAX_BURST) : 8'(rem_q);

    assign rd_req    = (state_q == StBurst);
    assign rd_addr   = rd_req ? addr_q : '0;
    assign rd_len    = rd_req ? burst_len : '0;
    assign wr_addr   = wr_addr_q;
    assign eng_ready = eng_ready_q;
    assign busy      = (state_q != StIdle);
    assign irq       = irq_q;
    assign cmd_cnt   = cmd_cnt_q;

    // Queue storage write; no reset needed since occupancy guards reads
    always_ff @(posedge clk) begin
        if (push) begin
            mask_mem[wptr_q]  <= cmd_mask;
            raddr_mem[wptr_q] <= cmd_raddr;
            waddr_mem[wptr_q] <= cmd_waddr;
            words_mem[wptr_q] <= cmd_words;
        end
    end

    // Queue pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            occ_q  <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + PTR_W'(1);
            if (pop)  rptr_q <= rptr_q + PTR_W'(1);
            occ_q <= occ_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // FSM next state; WAIT looks at this cycle's completions so DONE follows the
    // last completion by exactly one cycle
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (occ_q != '0) state_d = StLoad;
            StLoad:  state_d = (words_mem[rptr_q] != '0) ? StBurst : StWait;
            StBurst: if (rd_ack && (rem_q == LEN_W'(burst_len))) state_d = StWait;
            StWait:  if ((done_q | eng_hit) == mask_q) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Active command datapath: latch on LOAD, advance on burst ack, track completions
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q      <= '0;
            done_q      <= '0;
            eng_ready_q <= '0;
            addr_q      <= '0;
            wr_addr_q   <= '0;
            rem_q       <= '0;
        end else begin
            eng_ready_q <= eng_ready_q & ~eng_valid;
            done_q      <= done_q | eng_hit;
            unique case (state_q)
                StLoad: begin
                    mask_q      <= mask_mem[rptr_q];
                    eng_ready_q <= mask_mem[rptr_q];
                    addr_q      <= raddr_mem[rptr_q];
                    wr_addr_q   <= waddr_mem[rptr_q];
                    rem_q       <= words_mem[rptr_q];
                end
                StBurst: begin
                    if (rd_ack) begin
                        addr_q <= addr_q + ADDR_W'(burst_len);
                        rem_q  <= rem_q - LEN_W'(burst_len);
                    end
                end
                StDone:  done_q <= '0;
                default: ;
            endcase
        end
    end

    // Sticky interrupt (set beats clear) and completed-command counter
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_q     <= 1'b0;
            cmd_cnt_q <= '0;
        end else if (state_q == StDone) begin
            irq_q     <= 1'b1;
            cmd_cnt_q <= cmd_cnt_q + 16'd1;
        end else if (irq_clr) begin
            irq_q     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cmd_sched.sv
// Directed self-checking bench for cmd_sched (default parameters).
module tb_cmd_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_mask = '0;
    logic [31:0] cmd_raddr = '0;
    logic [31:0] cmd_waddr = '0;
    logic [15:0] cmd_words = '0;
    logic [3:0]  eng_ready;
    logic [3:0]  eng_valid = '0;
    logic        rd_req;
    logic        rd_ack = 1'b0;
    logic [31:0] rd_addr;
    logic [7:0]  rd_len;
    logic [31:0] wr_addr;
    logic        busy;
    logic        irq;
    logic        irq_clr = 1'b0;
    logic [15:0] cmd_cnt;

    int checks   = 0;
    int failures = 0;

    cmd_sched dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_mask  (cmd_mask),
        .cmd_raddr (cmd_raddr),
        .cmd_waddr (cmd_waddr),
        .cmd_words (cmd_words),
        .eng_ready (eng_ready),
        .eng_valid (eng_valid),
        .rd_req    (rd_req),
        .rd_ack    (rd_ack),
        .rd_addr   (rd_addr),
        .rd_len    (rd_len),
        .wr_addr   (wr_addr),
        .busy      (busy),
        .irq       (irq),
        .irq_clr   (irq_clr),
        .cmd_cnt   (cmd_cnt)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; inputs change and outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_cmd(input logic [3:0] m, input logic [31:0] ra, input logic [31:0] wa,
                           input logic [15:0] w);
        cmd_mask  = m;
        cmd_raddr = ra;
        cmd_waddr = wa;
        cmd_words = w;
    endtask

    task automatic push_cmd(input logic [3:0] m, input logic [31:0] ra, input logic [31:0] wa,
                            input logic [15:0] w);
        set_cmd(m, ra, wa, w);
        check("push_ready", cmd_ready, 1);
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (rd_req !== 1'b1 && n < 30) begin
            step();
            n++;
        end
        check(tag, rd_req, 1);
    endtask

    task automatic burst(input string tag, input logic [31:0] a, input logic [7:0] l);
        wait_req({tag, "_req"});
        check({tag, "_addr"}, rd_addr, a);
        check({tag, "_len"}, rd_len, l);
        rd_ack = 1'b1;
        step();
        rd_ack = 1'b0;
    endtask

    task automatic pulse_irq_clr();
        irq_clr = 1'b1;
        step();
        irq_clr = 1'b0;
    endtask

    initial begin
        int n;

        // Reset state
        step();
        step();
        rst = 1'b0;
        check("rst_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_irq", irq, 0);
        check("rst_cnt", cmd_cnt, 0);
        check("rst_eng", eng_ready, 0);
        check("rst_rdreq", rd_req, 0);
        check("rst_rdaddr", rd_addr, 0);
        check("rst_rdlen", rd_len, 0);
        check("rst_wraddr", wr_addr, 0);

        // 40 words from 0x1000 on engine 1: three bursts 16/16/8
        push_cmd(4'b0010, 32'h1000, 32'h2000, 16'd40);
        burst("a0", 32'h1000, 8'd16);
        check("a_eng", eng_ready, 4'b0010);
        check("a_wraddr", wr_addr, 32'h2000);
        burst("a1", 32'h1010, 8'd16);
        burst("a2", 32'h1020, 8'd8);
        check("a_req_drop", rd_req, 0);
        check("a_wait_busy", busy, 1);
        eng_valid = 4'b0001;            // engine outside the mask: ignored
        step();
        eng_valid = 4'b0000;
        check("a_ignore_eng", eng_ready, 4'b0010);
        check("a_ignore_busy", busy, 1);
        step();
        check("a_still_wait", busy, 1);
        eng_valid = 4'b0010;
        step();
        eng_valid = 4'b0000;
        check("a_eng_fall", eng_ready, 0);
        check("a_done_busy", busy, 1);
        step();
        check("a_irq", irq, 1);
        check("a_cnt", cmd_cnt, 1);
        check("a_idle", busy, 0);
        pulse_irq_clr();
        check("a_irq_clr", irq, 0);

        // Two engines, one finishing during BURST, the other 20 cycles after the last burst
        push_cmd(4'b0011, 32'h0, 32'h4000, 16'd20);
        wait_req("b_req");
        check("b_eng", eng_ready, 4'b0011);
        eng_valid = 4'b0001;
        step();
        eng_valid = 4'b0000;
        check("b_eng0_fall", eng_ready, 4'b0010);
        check("b_req_hold", rd_req, 1);
        burst("b0", 32'h0, 8'd16);
        burst("b1", 32'h10, 8'd4);
        check("b_req_drop", rd_req, 0);
        repeat (19) step();
        check("b_wait_busy", busy, 1);
        eng_valid = 4'b0010;
        step();
        eng_valid = 4'b0000;
        check("b_done_busy", busy, 1);
        check("b_done_irq", irq, 0);
        check("b_done_eng", eng_ready, 0);
        step();
        check("b_irq", irq, 1);
        check("b_cnt", cmd_cnt, 2);
        check("b_idle", busy, 0);

        // NOP: LOAD, WAIT, DONE back to back; irq_clr in the DONE cycle loses to set
        push_cmd(4'b0000, 32'h5000, 32'h6000, 16'd0);
        step();
        check("n_load_busy", busy, 1);
        check("n_load_req", rd_req, 0);
        step();
        check("n_wait_req", rd_req, 0);
        check("n_wait_eng", eng_ready, 0);
        step();
        check("n_done_busy", busy, 1);
        check("n_done_req", rd_req, 0);
        irq_clr = 1'b1;
        step();
        irq_clr = 1'b0;
        check("n_irq_set_wins", irq, 1);
        check("n_cnt", cmd_cnt, 3);
        check("n_idle", busy, 0);
        pulse_irq_clr();
        check("n_irq_clr", irq, 0);

        // Stalled engine 2 blocks pops; fill the queue and hold a 9th push
        push_cmd(4'b0100, 32'h0, 32'h0, 16'd0);
        step();
        step();
        check("q_stall_eng", eng_ready, 4'b0100);
        set_cmd(4'b0000, 32'h0, 32'h0, 16'd0);
        cmd_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("q_ready_fill", cmd_ready, 1);
            step();
        end
        check("q_full", cmd_ready, 0);
        step();
        check("q_full_hold", cmd_ready, 0);
        eng_valid = 4'b0100;
        step();                         // -> DONE
        eng_valid = 4'b0000;
        check("q_done_full", cmd_ready, 0);
        step();                         // -> IDLE
        check("q_idle_full", cmd_ready, 0);
        step();                         // -> LOAD (pop at next edge)
        check("q_load_full", cmd_ready, 0);
        step();
        check("q_ready_after_pop", cmd_ready, 1);
        step();                         // 9th push accepted here
        check("q_refull", cmd_ready, 0);
        cmd_valid = 1'b0;
        n = 0;
        while (cmd_cnt !== 16'd13 && n < 100) begin
            step();
            n++;
        end
        check("q_drain_cnt", cmd_cnt, 13);
        repeat (3) step();
        check("q_drain_idle", busy, 0);
        check("q_drain_cnt_stable", cmd_cnt, 13);
        check("q_drain_ready", cmd_ready, 1);
        pulse_irq_clr();
        check("q_irq_clr", irq, 0);

        // Address wrap, rd_ack held low, then reset mid-BURST with a concurrent push
        push_cmd(4'b0001, 32'hFFFF_FFF8, 32'h3000, 16'd24);
        wait_req("w_req");
        for (int i = 0; i < 5; i++) begin
            check("w_hold_addr", rd_addr, 32'hFFFF_FFF8);
            check("w_hold_len", rd_len, 16);
            step();
        end
        check("w_hold_req", rd_req, 1);
        rd_ack = 1'b1;
        step();
        rd_ack = 1'b0;
        check("w_wrap_addr", rd_addr, 32'h0000_0008);
        check("w_wrap_len", rd_len, 8);
        check("w_wraddr", wr_addr, 32'h3000);
        set_cmd(4'b0000, 32'h0, 32'h0, 16'd0);
        cmd_valid = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        cmd_valid = 1'b0;
        check("r_busy", busy, 0);
        check("r_req", rd_req, 0);
        check("r_addr", rd_addr, 0);
        check("r_len", rd_len, 0);
        check("r_wraddr", wr_addr, 0);
        check("r_eng", eng_ready, 0);
        check("r_irq", irq, 0);
        check("r_cnt", cmd_cnt, 0);
        check("r_ready", cmd_ready, 1);
        repeat (5) step();
        check("r_push_dropped_busy", busy, 0);
        check("r_push_dropped_cnt", cmd_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
